// File: rtl/ons_pkg.sv
// Shared definitions for the ons BCD conversion stage: FSM encoding,
// digit count and the double-dabble correction threshold.
package ons_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int         DIGITS      = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/ons_bcd_adj4.sv
// Per-digit double-dabble correction: add 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module ons_bcd_adj4
    import ons_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= ADD3_THRESH) ? i_dig + 4'd3 : i_dig;

endmodule

// File: rtl/ons_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock,
// valid/ready on both sides. Optional leading-zero mask via ONS_BCD_BLANK_EN.
module ons_bcd_conv
    import ons_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  bcd,
    output logic [3:0]   blank
);

    localparam int CW = $clog2(W + 1);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [15:0]         r_scr;
    logic [W-1:0]        r_sh;
    logic [15:0]         r_bcd;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [15:0]         w_adj;
    logic [15:0]         w_scr_nxt;
    logic                w_last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        ons_bcd_adj4 u_adj (
            .i_dig (r_scr[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    // Corrected digits shift left with the next binary MSB entering at bit 0.
    assign w_scr_nxt = {w_adj[14:0], r_sh[W-1]};
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_scr       <= '0;
            r_sh        <= '0;
            r_bcd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sh       <= bin;
                        r_scr      <= '0;
                        r_cnt      <= CW'(W);
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scr <= w_scr_nxt;
                    r_sh  <= r_sh << 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_bcd       <= w_scr_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ONS_BCD_BLANK_EN
    logic [3:0] r_blank;
    logic [3:0] w_blank_nxt;

    // Units digit is never blanked so a zero result still shows "0".
    always_comb begin
        w_blank_nxt    = 4'h0;
        w_blank_nxt[3] = (w_scr_nxt[15:12] == 4'd0);
        w_blank_nxt[2] = w_blank_nxt[3] && (w_scr_nxt[11:8] == 4'd0);
        w_blank_nxt[1] = w_blank_nxt[2] && (w_scr_nxt[7:4] == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_blank <= 4'hE;
        else if (w_last) r_blank <= w_blank_nxt;
    end

    assign blank = r_blank;
`else
    assign blank = 4'h0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;

endmodule

// File: tb/tb_ons_bcd_conv.sv
// Directed bench for ons_bcd_conv (default W=11); blank expectations follow
// ONS_BCD_BLANK_EN so the same bench serves both builds.
module tb_ons_bcd_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] bcd;
    logic [3:0]  blank;

    int checks = 0;
    int errors = 0;

    ons_bcd_conv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [15:0] b);
`ifdef ONS_BCD_BLANK_EN
        logic [3:0] m;
        m    = 4'h0;
        m[3] = (b[15:12] == 4'd0);
        m[2] = m[3] && (b[11:8] == 4'd0);
        m[1] = m[2] && (b[7:4] == 4'd0);
        return m;
`else
        return 4'h0;
`endif
    endfunction

    // Present v until accepted; returns at the negedge after the accept edge.
    task automatic send(input logic [10:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        in_valid = 1'b1;
        bin      = v;
        @(negedge clk);
        in_valid = 1'b0;
        bin      = '0;
        chk("busy_in_ready", in_ready, 1'b0);
    endtask

    // Wait for out_valid, checking latency from the accept edge and the result.
    task automatic wait_done(input string tag, input logic [15:0] exp_bcd);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 11);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        chk({tag, "_blank"}, blank, exp_blank(exp_bcd));
    endtask

    // With out_ready high, the next edge is the handshake (edge 12 from accept).
    task automatic after_hs(input string tag, input logic [15:0] exp_bcd);
        @(negedge clk);
        chk({tag, "_ovld_low"}, out_valid, 1'b0);
        chk({tag, "_iready"}, in_ready, 1'b1);
        chk({tag, "_bcd_kept"}, bcd, exp_bcd);
    endtask

    task automatic conv(input string tag, input logic [10:0] v, input logic [15:0] exp_bcd);
        send(v);
        wait_done(tag, exp_bcd);
        after_hs(tag, exp_bcd);
    endtask

    initial begin
        logic        seen;
        logic [15:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ovld", out_valid, 1'b0);
        chk("rst_bcd", bcd, 16'h0000);
`ifdef ONS_BCD_BLANK_EN
        chk("rst_blank", blank, 4'hE);
`else
        chk("rst_blank", blank, 4'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_iready", in_ready, 1'b1);

        // Directed conversions
        conv("b0",    11'd0,    16'h0000);
        conv("b29",   11'd29,   16'h0029);
        conv("b1140", 11'd1140, 16'h1140);
        conv("b2047", 11'd2047, 16'h2047);
        conv("b5",    11'd5,    16'h0005);
        conv("b999",  11'd999,  16'h0999);
        conv("b1000", 11'd1000, 16'h1000);

        // Consumer stall: result held, inputs ignored
        out_ready = 1'b0;
        send(11'd1140);
        wait_done("stall", 16'h1140);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            bin      = 11'd7;
            @(negedge clk);
            chk("stall_ovld", out_valid, 1'b1);
            chk("stall_bcd", bcd, 16'h1140);
            chk("stall_iready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        bin       = '0;
        out_ready = 1'b1;
        after_hs("stall", 16'h1140);

        // Reset mid-conversion aborts with no result
        send(11'd1140);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ovld", out_valid, 1'b0);
        chk("abort_bcd", bcd, 16'h0000);
        chk("abort_iready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 1'b0);
        chk("abort_bcd_idle", bcd, 16'h0000);
        conv("b57", 11'd57, 16'h0057);
`ifdef ONS_BCD_BLANK_EN
        chk("b57_blank_lit", blank, 4'b1100);
`else
        chk("b57_blank_lit", blank, 4'h0);
`endif

        // Back-to-back stream 1..40
        for (int i = 1; i <= 40; i++) begin
            e = 16'((i / 10) << 4) | 16'(i % 10);
            send(11'(i));
            wait_done("seq", e);
            after_hs("seq", e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
